// File: rtl/bsg_8b10b_tx_framer.sv
// 8b/10b transmit sequencer: reset comma train, idle/periodic K28.5 fill, running disparity ownership.
// Latency: a character handshaken at a tx_ready_i edge is on data_o from that edge; tx_ready_i low stalls everything.

module bsg_8b10b_encode_comb (
  input  logic [7:0] data_i,
  input  logic       k_i,
  input  logic       rd_i,
  output logic [9:0] data_o,
  output logic       rd_o,
  output logic       kerr_o
);

  // 5b/6b codes in RD- form, written abcdei with a as the MSB of the literal
  function automatic logic [5:0] code6(input logic [4:0] x);
    case (x)
      5'd0:    code6 = 6'b100111;
      5'd1:    code6 = 6'b011101;
      5'd2:    code6 = 6'b101101;
      5'd3:    code6 = 6'b110001;
      5'd4:    code6 = 6'b110101;
      5'd5:    code6 = 6'b101001;
      5'd6:    code6 = 6'b011001;
      5'd7:    code6 = 6'b111000;
      5'd8:    code6 = 6'b111001;
      5'd9:    code6 = 6'b100101;
      5'd10:   code6 = 6'b010101;
      5'd11:   code6 = 6'b110100;
      5'd12:   code6 = 6'b001101;
      5'd13:   code6 = 6'b101100;
      5'd14:   code6 = 6'b011100;
      5'd15:   code6 = 6'b010111;
      5'd16:   code6 = 6'b011011;
      5'd17:   code6 = 6'b100011;
      5'd18:   code6 = 6'b010011;
      5'd19:   code6 = 6'b110010;
      5'd20:   code6 = 6'b001011;
      5'd21:   code6 = 6'b101010;
      5'd22:   code6 = 6'b011010;
      5'd23:   code6 = 6'b111010;
      5'd24:   code6 = 6'b110011;
      5'd25:   code6 = 6'b100110;
      5'd26:   code6 = 6'b010110;
      5'd27:   code6 = 6'b110110;
      5'd28:   code6 = 6'b001110;
      5'd29:   code6 = 6'b101110;
      5'd30:   code6 = 6'b011110;
      default: code6 = 6'b101011;
    endcase
  endfunction

  // 3b/4b codes in RD- form, written fghj with f as the MSB of the literal
  function automatic logic [3:0] code4(input logic [2:0] y);
    case (y)
      3'd0:    code4 = 4'b1011;
      3'd1:    code4 = 4'b1001;
      3'd2:    code4 = 4'b0101;
      3'd3:    code4 = 4'b1100;
      3'd4:    code4 = 4'b1101;
      3'd5:    code4 = 4'b1010;
      3'd6:    code4 = 4'b0110;
      default: code4 = 4'b1110;
    endcase
  endfunction

  logic [4:0] x;
  logic [2:0] y;
  logic       is_k28;
  logic       k_x7;
  logic [5:0] c6m;
  logic [5:0] c6;
  logic       n6;
  logic       rd6;
  logic       use_a7;
  logic [3:0] c4m;
  logic [3:0] c4;
  logic       n4;
  logic       flip4;

  always_comb begin
    x      = data_i[4:0];
    y      = data_i[7:5];
    is_k28 = k_i & (x == 5'd28);
    k_x7   = (y == 3'd7) & ((x == 5'd23) | (x == 5'd27) | (x == 5'd29) | (x == 5'd30));
    kerr_o = k_i & ~(is_k28 | k_x7);

    c6m = is_k28 ? 6'b001111 : code6(x);
    n6  = ($countones(c6m) != 3);
    // D.07 is neutral but still has a distinct RD+ form
    c6  = (rd_i & (n6 | (x == 5'd7))) ? ~c6m : c6m;
    rd6 = rd_i ^ n6;

    // alternate x.7 avoids a run of five identical bits across the sub-block boundary
    use_a7 = (y == 3'd7) &
             (k_i | (~rd6 & ((x == 5'd17) | (x == 5'd18) | (x == 5'd20)))
                  | ( rd6 & ((x == 5'd11) | (x == 5'd13) | (x == 5'd14))));
    c4m = use_a7 ? 4'b0111 : code4(y);
    n4  = ($countones(c4m) != 2);
    // K28 neutral trailers are the inverse of the data forms so the comma stays unique
    if (is_k28 & ~n4 & (y != 3'd3)) flip4 = ~rd6;
    else                            flip4 = rd6 & (n4 | (y == 3'd3));
    c4   = flip4 ? ~c4m : c4m;
    rd_o = rd6 ^ n4;

    data_o = {c4[0], c4[1], c4[2], c4[3], c6[0], c6[1], c6[2], c6[3], c6[4], c6[5]};
  end

endmodule

module bsg_8b10b_tx_framer #(
  parameter int comma_period_p = 256,
  parameter int init_commas_p  = 16
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] data_i,
  input  logic       k_i,
  input  logic       v_i,
  output logic       ready_o,
  input  logic       tx_ready_i,
  output logic [9:0] data_o,
  output logic       rd_o,
  output logic       err_o
);

  localparam int data_cnt_w = $clog2(comma_period_p + 1);
  localparam int init_cnt_w = (init_commas_p > 1) ? $clog2(init_commas_p) : 1;
  localparam logic [data_cnt_w-1:0] period_lp    = data_cnt_w'(comma_period_p);
  localparam logic [init_cnt_w-1:0] init_last_lp = init_cnt_w'(init_commas_p - 1);
  localparam logic [9:0] k285_rdn_lp = 10'h17C;
  localparam logic [9:0] k285_rdp_lp = 10'h283;

  typedef enum logic {e_init, e_run} state_e;

  state_e                  state, state_n;
  logic [init_cnt_w-1:0]   init_cnt;
  logic [data_cnt_w-1:0]   data_cnt;
  logic                    force_comma;
  logic                    take;
  logic [7:0]              enc_data;
  logic                    enc_k;
  logic [9:0]              enc_sym;
  logic                    enc_rd;
  logic                    enc_kerr;
  logic [9:0]              sym_n;
  logic                    rd_n;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)         state <= e_init;
    else if (tx_ready_i) state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (state == e_init && init_cnt == init_last_lp) state_n = e_run;
  end

  // ready_o is combinational from tx_ready_i; upstream must not gate v_i on it
  always_comb begin
    force_comma = (state == e_run) & (data_cnt == period_lp);
    ready_o     = (state == e_run) & tx_ready_i & ~force_comma;
    take        = v_i & ready_o;
    enc_data    = take ? data_i : 8'hBC;
    enc_k       = take ? k_i    : 1'b1;
  end

  bsg_8b10b_encode_comb encoder (
    .data_i (enc_data),
    .k_i    (enc_k),
    .rd_i   (rd_o),
    .data_o (enc_sym),
    .rd_o   (enc_rd),
    .kerr_o (enc_kerr)
  );

  // an illegal K is swallowed and replaced by the K28.5 of the current disparity
  always_comb begin
    sym_n = enc_kerr ? (rd_o ? k285_rdp_lp : k285_rdn_lp) : enc_sym;
    rd_n  = enc_kerr ? ~rd_o : enc_rd;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      data_o   <= k285_rdn_lp;
      rd_o     <= 1'b1;
      err_o    <= 1'b0;
      init_cnt <= '0;
      data_cnt <= '0;
    end else if (tx_ready_i) begin
      data_o <= sym_n;
      rd_o   <= rd_n;
      if (enc_kerr) err_o <= 1'b1;
      if (state == e_init) begin
        init_cnt <= init_cnt + init_cnt_w'(1);
      end else if (take & ~enc_kerr) begin
        data_cnt <= data_cnt + data_cnt_w'(1);
      end else begin
        data_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bsg_8b10b_tx_framer.sv
// Bench for bsg_8b10b_tx_framer: hand-derived vector table, directed corner sequences,
// and random traffic against a table-lookup 8b/10b slot model.
module tb_bsg_8b10b_tx_framer;

  localparam int PERIOD = 3;
  localparam int INIT   = 4;

  logic       clk = 1'b0;
  logic       reset_i = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       k_i = 1'b0;
  logic       v_i = 1'b0;
  logic       ready_o;
  logic       tx_ready_i = 1'b0;
  logic [9:0] data_o;
  logic       rd_o;
  logic       err_o;

  bsg_8b10b_tx_framer #(.comma_period_p(PERIOD), .init_commas_p(INIT)) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .data_i     (data_i),
    .k_i        (k_i),
    .v_i        (v_i),
    .ready_o    (ready_o),
    .tx_ready_i (tx_ready_i),
    .data_o     (data_o),
    .rd_o       (rd_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  // standard code tables, abcdei / fghj written MSB-first
  localparam logic [5:0] T6M [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  localparam logic [5:0] T6P [32] = '{
    6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
    6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
    6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
    6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
  localparam logic [3:0] T4M [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
  localparam logic [3:0] T4P [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
  localparam logic [3:0] K4M [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};
  localparam logic [3:0] K4P [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
  localparam logic [7:0] KLIST [13] = '{8'hBC, 8'h3C, 8'h1C, 8'h5C, 8'h7C, 8'h9C, 8'hDC, 8'hFC,
                                        8'hF7, 8'hFB, 8'hFD, 8'hFE, 8'h00};

  int n_chk = 0;
  int n_err = 0;

  int         m_loads;
  int         m_run;
  logic       m_rd;
  logic       m_err;
  logic [9:0] m_sym;
  logic       smp_rdy;

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic enc_model(input logic [7:0] d, input logic k, input logic rd,
                           output logic [9:0] sym, output logic rdo, output logic kerr);
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] c6;
    logic [3:0] c4;
    logic       rd6;
    x = d[4:0];
    y = d[7:5];
    kerr = k && !(x == 28 || (y == 7 && (x == 23 || x == 27 || x == 29 || x == 30)));
    if (k && x == 28) c6 = rd ? 6'b110000 : 6'b001111;
    else              c6 = rd ? T6P[x] : T6M[x];
    rd6 = ($countones(c6) == 3) ? rd : ($countones(c6) > 3);
    if (k && x == 28)
      c4 = rd ? K4P[y] : K4M[y];
    else if (y == 7 && (k || (!rd6 && (x == 17 || x == 18 || x == 20)) ||
                             (rd6 && (x == 11 || x == 13 || x == 14))))
      c4 = rd6 ? 4'b1000 : 4'b0111;
    else
      c4 = rd6 ? T4P[y] : T4M[y];
    for (int i = 0; i < 6; i++) sym[i] = c6[5-i];
    for (int i = 0; i < 4; i++) sym[6+i] = c4[3-i];
    rdo = ($countones(sym) == 5) ? rd : ($countones(sym) > 5);
  endtask

  task automatic model_reset();
    m_loads = 0;
    m_run   = 0;
    m_rd    = 1'b1;
    m_err   = 1'b0;
    m_sym   = 10'h17C;
  endtask

  task automatic model_comma();
    logic [9:0] s;
    logic       r, ke;
    enc_model(8'hBC, 1'b1, m_rd, s, r, ke);
    m_sym = s;
    m_rd  = r;
  endtask

  // one serializer slot: drive at negedge, sample ready, update model at posedge, sample outputs
  task automatic drive(input logic v, input logic [7:0] d, input logic k, input logic txr, input logic chk);
    logic       exp_rdy, r, ke;
    logic [9:0] s;
    @(negedge clk);
    v_i = v; data_i = d; k_i = k; tx_ready_i = txr;
    #1;
    exp_rdy = txr && (m_loads >= INIT) && (m_run < PERIOD);
    smp_rdy = ready_o;
    if (chk) check("ready", {9'b0, ready_o}, {9'b0, exp_rdy});
    @(posedge clk);
    #1;
    if (txr) begin
      if (m_loads < INIT) begin
        model_comma();
        m_loads++;
      end else if (v && exp_rdy) begin
        enc_model(d, k, m_rd, s, r, ke);
        if (ke) begin
          model_comma();
          m_run = 0;
          m_err = 1'b1;
        end else begin
          m_sym = s;
          m_rd  = r;
          m_run++;
        end
      end else begin
        model_comma();
        m_run = 0;
      end
    end
    if (chk) begin
      check("data", data_o, m_sym);
      check("rd", {9'b0, rd_o}, {9'b0, m_rd});
      check("err", {9'b0, err_o}, {9'b0, m_err});
    end
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       k;
    logic       rdy;
    logic [9:0] sym;
    logic       rd;
  } vec_t;

  vec_t vq[$];

  initial begin
    logic [9:0] hold_sym;
    logic       hold_rd;
    logic [7:0] rd8;
    logic       rk;
    vec_t       vc;

    // consecutive RUN slots starting right after INIT (RD+), comma forced every 4th slot
    vq.push_back('{1'b1, 8'hB5, 1'b0, 1'b1, 10'h155, 1'b1});
    vq.push_back('{1'b1, 8'hB5, 1'b0, 1'b1, 10'h155, 1'b1});
    vq.push_back('{1'b1, 8'hB5, 1'b0, 1'b1, 10'h155, 1'b1});
    vq.push_back('{1'b1, 8'hB5, 1'b0, 1'b0, 10'h283, 1'b0});
    vq.push_back('{1'b1, 8'h00, 1'b0, 1'b1, 10'h0B9, 1'b0});
    vq.push_back('{1'b1, 8'h3C, 1'b1, 1'b1, 10'h27C, 1'b1});
    vq.push_back('{1'b1, 8'h4A, 1'b0, 1'b1, 10'h2AA, 1'b1});
    vq.push_back('{1'b1, 8'h4A, 1'b0, 1'b0, 10'h283, 1'b0});
    vq.push_back('{1'b1, 8'h67, 1'b0, 1'b1, 10'h0C7, 1'b0});
    vq.push_back('{1'b1, 8'hF7, 1'b1, 1'b1, 10'h057, 1'b0});
    vq.push_back('{1'b1, 8'hF1, 1'b0, 1'b1, 10'h3B1, 1'b1});
    vq.push_back('{1'b1, 8'hF1, 1'b0, 1'b0, 10'h283, 1'b0});
    vq.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 10'h17C, 1'b1});
    vq.push_back('{1'b1, 8'hFF, 1'b0, 1'b1, 10'h1CA, 1'b1});
    vq.push_back('{1'b1, 8'h00, 1'b0, 1'b1, 10'h346, 1'b1});
    vq.push_back('{1'b1, 8'hB5, 1'b0, 1'b1, 10'h155, 1'b1});
    vq.push_back('{1'b1, 8'hB5, 1'b0, 1'b0, 10'h283, 1'b0});

    // power-on reset
    #1 reset_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data", data_o, 10'h17C);
    check("rst_rd", {9'b0, rd_o}, 10'd1);
    check("rst_err", {9'b0, err_o}, 10'd0);
    check("rst_ready", {9'b0, ready_o}, 10'd0);
    @(negedge clk);
    reset_i = 1'b0;
    model_reset();

    // INIT comma train with valid data waiting
    for (int i = 0; i < INIT; i++) begin
      drive(1'b1, 8'hB5, 1'b0, 1'b1, 1'b1);
      check("init_data", data_o, (i % 2 == 0) ? 10'h283 : 10'h17C);
      check("init_ready", {9'b0, smp_rdy}, 10'd0);
    end

    // hand-derived vector table
    for (int i = 0; i < vq.size(); i++) begin
      vc = vq[i];
      drive(vc.v, vc.d, vc.k, 1'b1, 1'b0);
      check($sformatf("vec%0d_ready", i), {9'b0, smp_rdy}, {9'b0, vc.rdy});
      check($sformatf("vec%0d_data", i), data_o, vc.sym);
      check($sformatf("vec%0d_rd", i), {9'b0, rd_o}, {9'b0, vc.rd});
      check($sformatf("vec%0d_err", i), {9'b0, err_o}, 10'd0);
    end

    // illegal K0.0 at RD-: consumed, K28.5 RD- form sent, sticky error
    drive(1'b1, 8'h00, 1'b1, 1'b1, 1'b1);
    check("ilk_ready", {9'b0, smp_rdy}, 10'd1);
    check("ilk_data", data_o, 10'h17C);
    check("ilk_rd", {9'b0, rd_o}, 10'd1);
    check("ilk_err", {9'b0, err_o}, 10'd1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'hB5, 1'b0, 1'b1, 1'b1);
      check("ilk_sticky", {9'b0, err_o}, 10'd1);
    end

    // backpressure 1,0,0,1: outputs frozen while the serializer stalls
    drive(1'b1, 8'h00, 1'b0, 1'b1, 1'b1);
    hold_sym = data_o;
    hold_rd  = rd_o;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 8'h4A, 1'b0, 1'b0, 1'b1);
      check("bp_ready", {9'b0, smp_rdy}, 10'd0);
      check("bp_data_hold", data_o, hold_sym);
      check("bp_rd_hold", {9'b0, rd_o}, {9'b0, hold_rd});
    end
    drive(1'b1, 8'h4A, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 8'h67, 1'b0, 1'b1, 1'b1);

    // asynchronous reset in the middle of a slot
    @(negedge clk);
    v_i = 1'b1; data_i = 8'hB5; k_i = 1'b0; tx_ready_i = 1'b1;
    #2 reset_i = 1'b1;
    #1;
    check("mrst_data", data_o, 10'h17C);
    check("mrst_rd", {9'b0, rd_o}, 10'd1);
    check("mrst_err", {9'b0, err_o}, 10'd0);
    check("mrst_ready", {9'b0, ready_o}, 10'd0);
    @(posedge clk);
    #1;
    check("mrst_hold", data_o, 10'h17C);
    @(negedge clk);
    reset_i = 1'b0;
    tx_ready_i = 1'b0;
    model_reset();
    drive(1'b1, 8'hB5, 1'b0, 1'b1, 1'b1);
    check("mrst_first_load", data_o, 10'h283);
    for (int i = 0; i < INIT + 2; i++) drive(1'b1, 8'hB5, 1'b0, 1'b1, 1'b1);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      rk  = ($urandom_range(0, 9) == 0);
      rd8 = rk ? KLIST[$urandom_range(0, 12)] : 8'($urandom_range(0, 255));
      drive($urandom_range(0, 3) != 0, rd8, rk, $urandom_range(0, 4) != 0, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
